// File: rtl/seg_scan_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; non-decimal codes 10..15 show a dash.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit (parameterised) display scan controller with per-frame snapshot and per-dwell blanking.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int PRESCALE_W   = 10,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  hard_reset,
    input  logic                  scan_en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [2:0]            digit_idx,
    output logic                  frame_start
);

    localparam logic [PRESCALE_W-1:0] BLANK_LAST = PRESCALE_W'(BLANK_CYCLES - 1);
    localparam logic [PRESCALE_W-1:0] CNT_LAST   = '1;
    localparam logic [2:0]            IDX_LAST   = 3'(DIGITS - 1);

    scan_state_e             state_q;
    logic [PRESCALE_W-1:0]   cnt_q;
    logic [2:0]              idx_q;
    logic [4*DIGITS-1:0]     snap_bcd_q;
    logic [DIGITS-1:0]       snap_dp_q;
    logic                    frame_start_q;

    logic [PRESCALE_W-1:0]   cnt_d;
    assign cnt_d = cnt_q + PRESCALE_W'(1);

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_bcd_q    <= '0;
            snap_dp_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (scan_en) begin
                        state_q       <= BLANK;
                        snap_bcd_q    <= bcd_in;
                        snap_dp_q     <= dp_in;
                        frame_start_q <= 1'b1;
                    end
                end
                BLANK: begin
                    if (!scan_en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= ON;
                        end
                    end
                end
                ON: begin
                    if (!scan_en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= BLANK;
                            // Snapshot only at the frame boundary so a frame never tears.
                            if (idx_q == IDX_LAST) begin
                                idx_q         <= '0;
                                snap_bcd_q    <= bcd_in;
                                snap_dp_q     <= dp_in;
                                frame_start_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Pad to eight slots so the 3-bit index always addresses a full array.
    logic [3:0] digit_arr [8];
    logic [7:0] dp_pad;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < DIGITS) begin : g_real
                assign digit_arr[gi] = snap_bcd_q[4*gi +: 4];
                assign dp_pad[gi]    = snap_dp_q[gi];
            end else begin : g_zero
                assign digit_arr[gi] = 4'd0;
                assign dp_pad[gi]    = 1'b0;
            end
        end
    endgenerate

    logic       lit;
    logic [3:0] cur_bcd;
    logic [6:0] seg_raw;
    logic       lz_hit;

    assign lit     = (state_q == ON);
    assign cur_bcd = digit_arr[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_bcd),
        .seg_o (seg_raw)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [7:0] zero_above;
    logic [7:0] lz_mask;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lz
            if (gi == 7) begin : g_top
                assign zero_above[gi] = 1'b1;
            end else begin : g_chain
                assign zero_above[gi] = zero_above[gi+1] && (digit_arr[gi+1] == 4'd0);
            end
            if (gi == 0) begin : g_lsd
                assign lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign lz_mask[gi] = zero_above[gi] && (digit_arr[gi] == 4'd0);
            end
        end
    endgenerate

    assign lz_hit = lz_mask[idx_q];
`else
    assign lz_hit = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign digit_sel[gi] = lit && (idx_q == 3'(gi));
        end
    endgenerate

    assign seg_out     = (lit && !lz_hit) ? seg_raw : SEG_BLANK;
    assign dp_out      = lit && dp_pad[idx_q];
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=6, PRESCALE_W=3, BLANK_CYCLES=2); honours SEG_SCAN_LZ_BLANK_EN.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        hard_reset;
    logic        scan_en;
    logic [23:0] bcd_in;
    logic [5:0]  dp_in;
    logic [5:0]  digit_sel;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  digit_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS       (6),
        .PRESCALE_W   (3),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .hard_reset  (hard_reset),
        .scan_en     (scan_en),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .digit_sel   (digit_sel),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [5:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       fs;
    } obs_t;

    obs_t  exp_q [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [5:0] dp_pat = 6'b000100;

    // Segment images packed {digit5 .. digit0}.
    localparam logic [41:0] F123456 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
    localparam logic [41:0] F999999 = {7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F};
    localparam logic [41:0] F1234A6 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h40, 7'h7D};
`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic [41:0] F000070 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h07, 7'h3F};
    localparam logic [41:0] F000000 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
`else
    localparam logic [41:0] F000070 = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h07, 7'h3F};
    localparam logic [41:0] F000000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

    task automatic cyc(input logic [5:0] sel, input logic [6:0] seg, input logic dp,
                       input logic [2:0] idx, input logic fs, input string tag);
        obs_t e;
        @(posedge clk);
        #1;
        e.sel = sel; e.seg = seg; e.dp = dp; e.idx = idx; e.fs = fs;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One digit dwell: two dark cycles, then nlit lit cycles; bcd_in may change before cycle chg_at.
    task automatic dwell(input int d, input logic [6:0] seg, input int nlit,
                         input logic [23:0] nb, input int chg_at, input string tag);
        logic [5:0] sel;
        logic [2:0] di;
        sel = 6'b000001 << d;
        di  = d[2:0];
        for (int k = 0; k < 2 + nlit; k++) begin
            if (k == chg_at) bcd_in = nb;
            if (k < 2) cyc(6'b0, 7'h00, 1'b0, di, (d == 0) && (k == 0), tag);
            else       cyc(sel, seg, dp_pat[d], di, 1'b0, tag);
        end
    endtask

    task automatic frame(input logic [41:0] segs, input string tag);
        for (int d = 0; d < 6; d++) dwell(d, segs[7*d +: 7], 6, 24'h0, -1, tag);
    endtask

    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.sel = digit_sel; a.seg = seg_out; a.dp = dp_out; a.idx = digit_idx; a.fs = frame_start;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t: got sel=%b seg=%h dp=%b idx=%0d fs=%b, want sel=%b seg=%h dp=%b idx=%0d fs=%b",
                         t, $time, a.sel, a.seg, a.dp, a.idx, a.fs, e.sel, e.seg, e.dp, e.idx, e.fs);
            end else begin
                $display("ok   %s t=%0t sel=%b seg=%h dp=%b idx=%0d fs=%b",
                         t, $time, a.sel, a.seg, a.dp, a.idx, a.fs);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1);
    end

    initial begin
        hard_reset = 1'b1;
        scan_en    = 1'b1;
        bcd_in     = 24'h123456;
        dp_in      = 6'b000100;

        repeat (3) cyc(6'b0, 7'h00, 1'b0, 3'd0, 1'b0, "reset");
        hard_reset = 1'b0;

        frame(F123456, "scan");

        for (int d = 0; d < 3; d++) dwell(d, F123456[7*d +: 7], 6, 24'h0, -1, "snap_old");
        dwell(3, F123456[21 +: 7], 6, 24'h999999, 4, "snap_old");
        for (int d = 4; d < 6; d++) dwell(d, F123456[7*d +: 7], 6, 24'h0, -1, "snap_old");

        for (int d = 0; d < 5; d++) dwell(d, F999999[7*d +: 7], 6, 24'h0, -1, "snap_new");
        dwell(5, F999999[35 +: 7], 6, 24'h1234A6, 0, "snap_new");

        for (int d = 0; d < 4; d++) dwell(d, F1234A6[7*d +: 7], 6, 24'h0, -1, "invalid");
        dwell(4, F1234A6[28 +: 7], 3, 24'h0, -1, "invalid");
        scan_en = 1'b0;
        repeat (3) cyc(6'b0, 7'h00, 1'b0, 3'd0, 1'b0, "disable");

        bcd_in  = 24'h000070;
        scan_en = 1'b1;
        for (int d = 0; d < 5; d++) dwell(d, F000070[7*d +: 7], 6, 24'h0, -1, "lz_70");
        dwell(5, F000070[35 +: 7], 6, 24'h000000, 0, "lz_70");
        frame(F000000, "lz_zero");

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left in queue, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
